// File: rtl/nios2_qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu. Operands are captured on an
// accepted start, a purely unsigned core produces one quotient bit per cycle,
// and a final cycle applies signs or the divide-by-zero convention.
module nios2_qsys_cpu_div_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_signed,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] M_div_quot,
  output logic [WIDTH-1:0] M_div_rem,
  output logic             M_div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;        // dividend magnitude, becomes quotient as it shifts
  logic [WIDTH-1:0] dsr;        // divisor magnitude
  logic [WIDTH-1:0] prem;       // partial remainder
  logic [WIDTH-1:0] src1_orig;  // untouched dividend for the divide-by-zero result
  logic             neg_q;
  logic             neg_r;
  logic             dbz;

  logic             src1_neg_c;
  logic             src2_neg_c;
  logic [WIDTH-1:0] mag1_c;
  logic [WIDTH-1:0] mag2_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;
  logic             sub_ok_c;
  logic [WIDTH-1:0] prem_nxt_c;

  // Operand magnitudes; -2^(WIDTH-1) maps onto unsigned 2^(WIDTH-1)
  always_comb begin
    src1_neg_c = E_signed & E_src1[WIDTH-1];
    src2_neg_c = E_signed & E_src2[WIDTH-1];
    mag1_c     = src1_neg_c ? -E_src1 : E_src1;
    mag2_c     = src2_neg_c ? -E_src2 : E_src2;
  end

  // One restoring step: shift in next dividend bit, trial-subtract, keep if non-negative
  always_comb begin
    shifted_c  = {prem, dvd[WIDTH-1]};
    diff_c     = shifted_c - {1'b0, dsr};
    sub_ok_c   = ~diff_c[WIDTH];
    prem_nxt_c = sub_ok_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      dvd           <= '0;
      dsr           <= '0;
      prem          <= '0;
      src1_orig     <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dbz           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      M_div_quot    <= '0;
      M_div_rem     <= '0;
      M_div_by_zero <= 1'b0;
    end else begin
      busy <= (state == S_RUN) || (state == S_FIX);
      done <= (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dvd       <= mag1_c;
            dsr       <= mag2_c;
            prem      <= '0;
            cnt       <= CW'(WIDTH - 1);
            neg_q     <= E_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
            neg_r     <= src1_neg_c;
            dbz       <= (E_src2 == '0);
            src1_orig <= E_src1;
          end
        end
        S_RUN: begin
          dvd  <= {dvd[WIDTH-2:0], sub_ok_c};
          prem <= prem_nxt_c;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          if (dbz) begin
            M_div_quot    <= '1;
            M_div_rem     <= src1_orig;
            M_div_by_zero <= 1'b1;
          end else begin
            M_div_quot    <= neg_q ? -dvd : dvd;
            M_div_rem     <= neg_r ? -prem : prem;
            M_div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_qsys_cpu_div_cell.sv
// Self-checking bench for the restoring divider: directed corners, handshake,
// reset abort and randomized operations against an arithmetic reference.
module tb_nios2_qsys_cpu_div_cell;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] E_src1 = '0;
  logic [W-1:0] E_src2 = '0;
  logic         E_signed = 1'b0;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] M_div_quot;
  logic [W-1:0] M_div_rem;
  logic         M_div_by_zero;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_z = 1'b0;

  nios2_qsys_cpu_div_cell #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .E_src1        (E_src1),
    .E_src2        (E_src2),
    .E_signed      (E_signed),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .M_div_quot    (M_div_quot),
    .M_div_rem     (M_div_rem),
    .M_div_by_zero (M_div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Truncating division on wide integers; zero divisor gives all ones / dividend
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // One operation, start accepted at edge 0; g1/g2 are edges with ignored start pulses
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int g1, input int g2, input string tag);
    logic [W-1:0] eq, er, cq, cr;
    logic         ez, cz;
    int           busy_n, done_at;
    ref_div(a, b, s, eq, er, ez);
    busy_n  = 0;
    done_at = -1;
    cq = '0; cr = '0; cz = 1'b0;
    @(negedge clk);
    start = 1'b1; E_src1 = a; E_src2 = b; E_signed = s;
    @(posedge clk);
    for (int n = 1; n <= 60 && done_at < 0; n++) begin
      @(negedge clk);
      start = (n == g1) || (n == g2);
      if (start) begin
        E_src1   = $urandom;
        E_src2   = $urandom;
        E_signed = ~s;
      end
      @(posedge clk);
      #1;
      if (n == 1) check({tag, " done_idle"}, 64'(done), 64'(1'b0));
      if (n == 10) begin
        check({tag, " hold_quot"}, 64'(M_div_quot), 64'(prev_q));
        check({tag, " hold_rem"}, 64'(M_div_rem), 64'(prev_r));
        check({tag, " hold_dbz"}, 64'(M_div_by_zero), 64'(prev_z));
      end
      if (busy) busy_n++;
      if (done) begin
        done_at = n;
        cq = M_div_quot; cr = M_div_rem; cz = M_div_by_zero;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(32'(done_at)), 64'd34);
    check({tag, " busy_cycles"}, 64'(32'(busy_n)), 64'd33);
    check({tag, " quot"}, 64'(cq), 64'(eq));
    check({tag, " rem"}, 64'(cr), 64'(er));
    check({tag, " dbz"}, 64'(cz), 64'(ez));
    prev_q = eq; prev_r = er; prev_z = ez;
  endtask

  initial begin
    logic seen_done;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'(1'b0));
    check("rst done", 64'(done), 64'(1'b0));
    check("rst quot", 64'(M_div_quot), 64'(32'h0));
    check("rst rem", 64'(M_div_rem), 64'(32'h0));
    check("rst dbz", 64'(M_div_by_zero), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op(32'd100, 32'd7, 1'b0, -1, -1, "u100_7");
    run_op(32'hFFFF_FFF9, 32'h2, 1'b1, -1, -1, "s-7_2");
    run_op(32'h7, 32'hFFFF_FFFE, 1'b1, -1, -1, "s7_-2");
    run_op(32'h5, 32'h0, 1'b1, -1, -1, "s5_0");
    run_op(32'hFFFF_FFF0, 32'h0, 1'b0, -1, -1, "uF0_0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, "s_ovf");
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, -1, -1, "uFF_1");
    run_op(32'h3, 32'hFFFF_FFFF, 1'b0, -1, -1, "u3_FF");

    // Ignored starts at edges 5 and 34, then a start accepted at edge 35
    run_op(32'd1234567, 32'd89, 1'b0, 5, 34, "hs_first");
    run_op(32'hDEAD_BEEF, 32'd1000, 1'b1, -1, -1, "hs_second");

    // Randomized operands, sometimes small or zero divisors
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = W'($urandom_range(0, 15));
      if (i % 4 == 2) rb = -W'($urandom_range(1, 15));
      run_op(ra, rb, 1'(i % 2), -1, -1, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of an operation aborts it
    @(negedge clk);
    start = 1'b1; E_src1 = 32'd123456; E_src2 = 32'd789; E_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", 64'(busy), 64'(1'b0));
    check("abort done", 64'(done), 64'(1'b0));
    check("abort quot", 64'(M_div_quot), 64'(32'h0));
    check("abort rem", 64'(M_div_rem), 64'(32'h0));
    check("abort dbz", 64'(M_div_by_zero), 64'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done;
    end
    check("abort no_done", 64'(seen_done), 64'(1'b0));
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    run_op(32'd1000, 32'd10, 1'b0, -1, -1, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
